// File: rtl/div_pkg.sv
// Shared types and helpers for the multi-cycle HI/LO divider.
// The MIPS funct codes let upstream decode drive start/is_signed.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam logic [5:0] DIV  = 6'b011010;
    localparam logic [5:0] DIVU = 6'b011011;

    // Widest operand the helper handles; callers zero-extend and truncate.
    localparam int DIV_MAX_W = 64;

    // Two's-complement negate when neg is set. Low bits are correct for any
    // narrower width, so callers cast the result back down.
    function automatic logic [DIV_MAX_W-1:0] cond_neg(
        input logic [DIV_MAX_W-1:0] v,
        input logic                 neg
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on {prem, q}.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] prem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] prem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           neg;

    // prem < divisor holds between steps, so WIDTH+1 bits cover the
    // shifted value and bit WIDTH of the difference is a valid sign.
    assign shifted   = {prem, q[WIDTH-1]};
    assign diff      = shifted - {1'b0, divisor};
    assign neg       = diff[WIDTH];
    assign prem_next = neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next    = {q[WIDTH-2:0], ~neg};

endmodule

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, signed/unsigned, with
// start/busy/done handshake, divide-by-zero flag and abort on restart.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] dataOut
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] prem, q, dvs, dvd_raw;
    logic             neg_q, neg_r, zero_dvs;

    logic [WIDTH-1:0] prem_nx, q_nx;
    logic [WIDTH-1:0] dvd_abs, dvs_abs, quot_fix, rem_fix;

    assign dvd_abs  = WIDTH'(cond_neg(DIV_MAX_W'(dividend), is_signed & dividend[WIDTH-1]));
    assign dvs_abs  = WIDTH'(cond_neg(DIV_MAX_W'(divisor), is_signed & divisor[WIDTH-1]));
    assign quot_fix = WIDTH'(cond_neg(DIV_MAX_W'(q), neg_q));
    assign rem_fix  = WIDTH'(cond_neg(DIV_MAX_W'(prem), neg_r));

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .q         (q),
        .divisor   (dvs),
        .prem_next (prem_nx),
        .q_next    (q_nx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            prem        <= '0;
            q           <= '0;
            dvs         <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_dvs    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            dataOut     <= '0;
        end else begin
            done <= 1'b0;
            // A start in any state (including mid-flight) recaptures and restarts.
            if (start) begin
                state    <= CALC;
                busy     <= 1'b1;
                cnt      <= '0;
                prem     <= '0;
                q        <= dvd_abs;
                dvs      <= dvs_abs;
                dvd_raw  <= dividend;
                neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r    <= is_signed & dividend[WIDTH-1];
                zero_dvs <= (divisor == '0);
            end else begin
                case (state)
                    CALC: begin
                        prem <= prem_nx;
                        q    <= q_nx;
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1))
                            state <= FIX;
                    end
                    FIX: begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= zero_dvs;
                        dataOut     <= zero_dvs ? {dvd_raw, {WIDTH{1'b1}}}
                                                : {rem_fix, quot_fix};
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_seq_divider;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   dividend, divisor;
    logic           busy, done, div_by_zero;
    logic [2*W-1:0] dataOut;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [2*W-1:0] data;
        logic           dbz;
        int             due;
        string          name;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .dataOut     (dataOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got dataOut %h expected no done", dataOut);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, dataOut, e.data);
                check({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
                check({e.name, "_lat"}, 64'(cyc), 64'(e.due));
                check({e.name, "_busy"}, 64'(busy), 64'd0);
            end
        end
    end

    // Called at a negedge; returns just after the capture edge.
    task automatic issue(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp_data,
                         input logic exp_dbz, input bit expect_it);
        exp_t e;
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check({name, "_busy_on"}, 64'(busy), 64'd1);
        if (expect_it) begin
            e.data = exp_data;
            e.dbz  = exp_dbz;
            e.due  = cyc + LAT;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done && n < 3 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, 3 * LAT);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_data", dataOut, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        issue("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1);
        wait_done("u100_7"); @(negedge clk);
        issue("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1);
        wait_done("s_m7_2"); @(negedge clk);
        issue("u_f9_2", 1'b0, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 1'b0, 1);
        wait_done("u_f9_2"); @(negedge clk);
        issue("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, 1);
        wait_done("s_ovf"); @(negedge clk);
        issue("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 1'b0, 1);
        wait_done("u_max_1"); @(negedge clk);
        issue("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, 1);
        wait_done("s_m100_7"); @(negedge clk);
        issue("dbz_5", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b1, 1);
        wait_done("dbz_5"); @(negedge clk);
        issue("dbz_s_m5", 1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, 1);
        wait_done("dbz_s_m5"); @(negedge clk);
        issue("clr_dbz", 1'b1, 32'd20, 32'd4, {32'd0, 32'd5}, 1'b0, 1);
        wait_done("clr_dbz"); @(negedge clk);

        // Restart mid-flight: the first operation must never complete.
        issue("abort_a", 1'b0, 32'd100, 32'd7, 64'd0, 1'b0, 0);
        repeat (9) @(negedge clk);
        issue("restart", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 1);
        wait_done("restart"); @(negedge clk);

        // Back-to-back: second start lands on the done cycle of the first.
        issue("b2b_a", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b0, 1);
        wait_done("b2b_a");
        issue("b2b_b", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b0, 1);
        wait_done("b2b_b"); @(negedge clk);

        // Reset mid-operation.
        issue("rst_mid", 1'b0, 32'd100, 32'd7, 64'd0, 1'b0, 0);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_data", dataOut, 64'd0);
        check("rst_mid_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 10) @(negedge clk);

        issue("post_rst", 1'b0, 32'd0, 32'd5, {32'd0, 32'd0}, 1'b0, 1);
        wait_done("post_rst");
        repeat (5) @(negedge clk);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
